dcache_snoop_responder: RTL and testbench
=========================================

Name: dcache_snoop_responder

Overview:
- Cache-side responder to the coherence controller's snoop and invalidate protocol, instantiated once per data cache.
- Accepts ccwait, ccsnoopaddr and ccinv from the controller.
- Looks the address up in the cache's 2-way tag/state frames, answers with cctrans/ccwrite, writes back a Modified block (two words), and issues frame state updates (M→S downgrade, invalidate).
- While busy it owns the cache's memory-side daddr/dstore/dWEN.

Parameters:
- SETS, 8, number of sets; IDX_W = log2(SETS).
- TAG_W, 26, tag width (32 - IDX_W - 3).

Ports:
- CLK  in  1  clock
- nRST  in  1  reset; one clock, reset is synchronous and active-low
- ccwait  in  1  controller is servicing another cache; snoop window open
- ccinv  in  1  invalidate request for ccsnoopaddr
- ccsnoopaddr  in  32  snooped byte address
- dwait  in  1  controller/memory wait for this cache's dWEN
- cctrans  out  1  snoop response valid
- ccwrite  out  1  with cctrans: block was Modified and will be written back
- snp_busy  out  1  responder owns daddr/dstore/dWEN; cache must mux these and stall its own requests
- snp_daddr  out  32  write-back address
- snp_dstore  out  32  write-back data
- snp_dWEN  out  1  write-back enable
- frm_idx  out  IDX_W  set index to frame arrays (combinational read)
- frm_valid  in  2  per-way valid
- frm_dirty  in  2  per-way dirty (valid & dirty = M; valid & !dirty = S)
- frm_tag  in  2xTAG_W  per-way tag
- frm_data  in  2x2x32  per-way, per-word data
- upd_en  out  1  one-cycle frame state write strobe
- upd_way  out  1  way to update
- upd_valid  out  1  new valid
- upd_dirty  out  1  new dirty

Behaviour:
- Address split: tag = [31:IDX_W+3], idx = [IDX_W+2:3], word = [2], byte = [1:0].
- frm_idx = latched idx in non-IDLE states; ccsnoopaddr idx in IDLE.
- Hit way: way whose frm_valid=1 and frm_tag = addr tag. Both ways matching is illegal; way 0 wins.
- Reset (nRST=0 at a CLK edge, any state, including mid write-back):
  - Next state IDLE; snoop address, way and dirty registers cleared.
  - All outputs 0, with no partial update strobe.
- FSM states:
  - IDLE: snp_busy = ccwait.
    - ccwait & ccinv: if hit, upd_en=1 combinationally this cycle, upd_way=hit way, upd_valid=0, upd_dirty=0. Next state WAITREL. A dirty block is discarded (controller guarantees the write-back happened earlier). Miss: no update, next state WAITREL.
    - ccwait & !ccinv: latch ccsnoopaddr, hit, hit way, hit&dirty; next state RESP.
  - RESP (exactly 1 cycle): cctrans=1, ccwrite=latched hit&dirty. Next state WB0 if dirty; else, if hit, stay S (no update). Next state WAITREL.
  - WB0: snp_dWEN=1, snp_daddr = {tag, idx, 3'b000}, snp_dstore = way data word0. Hold until dwait=0, then go to WB1.
  - WB1: same, with snp_daddr = {tag, idx, 3'b100} and word1. On dwait=0: upd_en=1, upd_valid=1, upd_dirty=0 (M→S), next state WAITREL.
  - WAITREL: snp_busy=1 while ccwait=1; go to IDLE when ccwait=0. This prevents re-snooping the same transaction.
- Priority and boundary cases:
  - ccinv during RESP/WB0/WB1 is ignored.
  - ccwait dropping during WB0/WB1 is a controller error; the responder still completes the write-back.
  - cctrans/ccwrite are high only in RESP.
  - snp_dWEN is high only in WB0/WB1.
  - upd_en lasts at most 1 cycle per snoop.
- Latency:
  - Snoop to cctrans: 1 cycle.
  - Dirty snoop: cctrans, then 2 writes, each ≥1 cycle plus dwait.

Test Plan:
- Reset: nRST=0 for 2 cycles mid-WB0 (dwait=1) → next cycle IDLE; snp_dWEN, cctrans, upd_en, snp_busy all 0.
- Snoop miss: ccwait=1, ccsnoopaddr=0x0000_1040, no tag match → cctrans=1, ccwrite=0 for one cycle; no upd_en; busy until ccwait=0.
- Snoop S hit: way1 valid, dirty=0, tag matches 0x0000_2048 → cctrans=1, ccwrite=0; no update; snp_dWEN never asserted.
- Snoop M hit with write-back: way0 M at idx 1, tag 0x40, data {0xDEAD_BEEF, 0x1234_5678}, dwait low after 3 cycles each → cctrans=1/ccwrite=1.
  - Then daddr 0x0000_1008 with dstore 0xDEAD_BEEF.
  - Then daddr 0x0000_100C with dstore 0x1234_5678.
  - Then upd_en: way0, valid=1, dirty=0.
- Invalidate: ccwait=1, ccinv=1, addr hits way1 → same-cycle upd_en, way1, valid=0; cctrans stays 0; after ccwait=0 returns to IDLE.
- Hold-off: ccwait held high 10 cycles after a clean snoop → exactly one cctrans pulse, no second RESP.

Source files
------------

// File: rtl/dcache_snoop_responder.sv
// rtl/dcache_snoop_responder.sv - data cache responder for coherence snoops and invalidates
module dcache_snoop_responder #(
    parameter int SETS  = 8,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 32 - IDX_W - 3
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 ccwait,
    input  logic                 ccinv,
    input  logic [31:0]          ccsnoopaddr,
    input  logic                 dwait,
    output logic                 cctrans,
    output logic                 ccwrite,
    output logic                 snp_busy,
    output logic [31:0]          snp_daddr,
    output logic [31:0]          snp_dstore,
    output logic                 snp_dWEN,
    output logic [IDX_W-1:0]     frm_idx,
    input  logic [1:0]           frm_valid,
    input  logic [1:0]           frm_dirty,
    input  logic [2*TAG_W-1:0]   frm_tag,
    input  logic [127:0]         frm_data,
    output logic                 upd_en,
    output logic                 upd_way,
    output logic                 upd_valid,
    output logic                 upd_dirty
);

    typedef enum logic [2:0] {IDLE, RESP, WB0, WB1, WAITREL} state_t;

    state_t             state;
    logic [TAG_W-1:0]   lat_tag;
    logic [IDX_W-1:0]   lat_idx;
    logic               lat_way;
    logic               lat_dirty;

    logic [TAG_W-1:0]   in_tag;
    logic [IDX_W-1:0]   in_idx;
    logic               hit0, hit1, hit, hit_way, hit_dirty;
    logic               wb_word;
    logic [1:0]         data_sel;
    logic               addr_unused;

    assign in_tag      = ccsnoopaddr[31:IDX_W+3];
    assign in_idx      = ccsnoopaddr[IDX_W+2:3];
    assign addr_unused = &{1'b0, ccsnoopaddr[2:0]};

    // Lookups only matter in IDLE, where frm_idx follows the incoming address.
    assign hit0      = frm_valid[0] && (frm_tag[TAG_W-1:0] == in_tag);
    assign hit1      = frm_valid[1] && (frm_tag[2*TAG_W-1:TAG_W] == in_tag);
    assign hit       = hit0 || hit1;
    assign hit_way   = !hit0;
    assign hit_dirty = hit && frm_dirty[hit_way];

    assign wb_word   = (state == WB1);
    assign data_sel  = {lat_way, wb_word};

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= IDLE;
            lat_tag   <= '0;
            lat_idx   <= '0;
            lat_way   <= 1'b0;
            lat_dirty <= 1'b0;
        end else begin
            case (state)
                IDLE: if (ccwait) begin
                    lat_tag   <= in_tag;
                    lat_idx   <= in_idx;
                    lat_way   <= hit_way;
                    lat_dirty <= hit_dirty && !ccinv;
                    state     <= ccinv ? WAITREL : RESP;
                end
                RESP:    state <= lat_dirty ? WB0 : WAITREL;
                WB0:     if (!dwait) state <= WB1;
                WB1:     if (!dwait) state <= WAITREL;
                WAITREL: if (!ccwait) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode the registered state; everything is forced low during reset.
    always_comb begin
        cctrans    = 1'b0;
        ccwrite    = 1'b0;
        snp_busy   = 1'b0;
        snp_daddr  = '0;
        snp_dstore = '0;
        snp_dWEN   = 1'b0;
        frm_idx    = '0;
        upd_en     = 1'b0;
        upd_way    = 1'b0;
        upd_valid  = 1'b0;
        upd_dirty  = 1'b0;
        if (nRST) begin
            frm_idx = (state == IDLE) ? in_idx : lat_idx;
            case (state)
                IDLE: begin
                    snp_busy = ccwait;
                    if (ccwait && ccinv && hit) begin
                        upd_en  = 1'b1;
                        upd_way = hit_way;
                    end
                end
                RESP: begin
                    snp_busy = 1'b1;
                    cctrans  = 1'b1;
                    ccwrite  = lat_dirty;
                end
                WB0, WB1: begin
                    snp_busy   = 1'b1;
                    snp_dWEN   = 1'b1;
                    snp_daddr  = {lat_tag, lat_idx, wb_word, 2'b00};
                    snp_dstore = frm_data[32*data_sel +: 32];
                    if (wb_word && !dwait) begin
                        upd_en    = 1'b1;
                        upd_way   = lat_way;
                        upd_valid = 1'b1;
                    end
                end
                WAITREL: snp_busy = ccwait;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// tb/tb_dcache_snoop_responder.sv - randomized and directed bench with transaction-level model
module tb_dcache_snoop_responder;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         ccwait, ccinv, dwait;
    logic [31:0]  ccsnoopaddr;
    logic         cctrans, ccwrite, snp_busy, snp_dWEN;
    logic [31:0]  snp_daddr, snp_dstore;
    logic [2:0]   frm_idx;
    logic [1:0]   frm_valid, frm_dirty;
    logic [51:0]  frm_tag;
    logic [127:0] frm_data;
    logic         upd_en, upd_way, upd_valid, upd_dirty;

    dcache_snoop_responder dut (
        .CLK(CLK), .nRST(nRST), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr), .dwait(dwait), .cctrans(cctrans),
        .ccwrite(ccwrite), .snp_busy(snp_busy), .snp_daddr(snp_daddr),
        .snp_dstore(snp_dstore), .snp_dWEN(snp_dWEN), .frm_idx(frm_idx),
        .frm_valid(frm_valid), .frm_dirty(frm_dirty), .frm_tag(frm_tag),
        .frm_data(frm_data), .upd_en(upd_en), .upd_way(upd_way),
        .upd_valid(upd_valid), .upd_dirty(upd_dirty)
    );

    always #5 CLK = ~CLK;

    // Cache frame contents, owned by the stimulus process.
    logic        fv   [8][2];
    logic        fd   [8][2];
    logic [25:0] ft   [8][2];
    logic [31:0] fdat [8][2][2];

    always_comb begin
        frm_valid = {fv[frm_idx][1], fv[frm_idx][0]};
        frm_dirty = {fd[frm_idx][1], fd[frm_idx][0]};
        frm_tag   = {ft[frm_idx][1], ft[frm_idx][0]};
        frm_data  = {fdat[frm_idx][1][1], fdat[frm_idx][1][0],
                     fdat[frm_idx][0][1], fdat[frm_idx][0][0]};
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    logic        chk_on = 1'b0;
    logic        exp_busy, exp_cctrans, exp_ccwrite, exp_dwen;
    logic [31:0] exp_daddr, exp_dstore;
    logic        exp_upd_en, exp_upd_way, exp_upd_valid, exp_upd_dirty;
    logic        chk_idx;
    logic [2:0]  exp_idx;

    always @(negedge CLK) begin
        if (chk_on) begin
            chk("snp_busy", snp_busy, exp_busy);
            chk("cctrans", cctrans, exp_cctrans);
            chk("ccwrite", ccwrite, exp_ccwrite);
            chk("snp_dWEN", snp_dWEN, exp_dwen);
            chk("upd_en", upd_en, exp_upd_en);
            if (exp_dwen) begin
                chk("snp_daddr", snp_daddr, exp_daddr);
                chk("snp_dstore", snp_dstore, exp_dstore);
            end
            if (exp_upd_en) begin
                chk("upd_way", upd_way, exp_upd_way);
                chk("upd_valid", upd_valid, exp_upd_valid);
                chk("upd_dirty", upd_dirty, exp_upd_dirty);
            end
            if (chk_idx) chk("frm_idx", frm_idx, exp_idx);
        end
    end

    // Event log for the literal pins of directed cases.
    int          mon_trans = 0, mon_dwen = 0, mon_upd = 0;
    logic        last_ccwrite, last_upd_way, last_upd_valid, last_upd_dirty;
    logic [63:0] wbq[$];

    always @(negedge CLK) begin
        if (cctrans) begin mon_trans++; last_ccwrite = ccwrite; end
        if (snp_dWEN) mon_dwen++;
        if (snp_dWEN && !dwait) wbq.push_back({snp_daddr, snp_dstore});
        if (upd_en) begin
            mon_upd++;
            last_upd_way = upd_way; last_upd_valid = upd_valid; last_upd_dirty = upd_dirty;
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic clr_exp();
        exp_busy = 0; exp_cctrans = 0; exp_ccwrite = 0; exp_dwen = 0;
        exp_daddr = 0; exp_dstore = 0; exp_upd_en = 0; exp_upd_way = 0;
        exp_upd_valid = 0; exp_upd_dirty = 0; chk_idx = 0; exp_idx = 0;
    endtask

    function automatic int hit_way_of(input logic [31:0] a);
        logic [2:0] ix = a[5:3];
        if (fv[ix][0] && ft[ix][0] == a[31:6]) return 0;
        if (fv[ix][1] && ft[ix][1] == a[31:6]) return 1;
        return -1;
    endfunction

    // One full snoop transaction, expectations derived from the protocol rules.
    task automatic snoop(input logic [31:0] a, input logic inv, input int hold, input bit rnd);
        int         w;
        logic [2:0] ix;
        logic       dirty;
        ix = a[5:3];
        w = hit_way_of(a);
        dirty = 0;
        if (w >= 0) dirty = fd[ix][w];

        ccwait = 1; ccinv = inv; ccsnoopaddr = a; dwait = 1'($urandom);
        clr_exp; exp_busy = 1; chk_idx = 1; exp_idx = ix;
        if (inv && w >= 0) begin exp_upd_en = 1; exp_upd_way = w[0]; end
        tick;
        if (inv && w >= 0) begin fv[ix][w] = 0; fd[ix][w] = 0; end

        if (!inv) begin
            ccinv = 1'($urandom); ccsnoopaddr = $urandom;
            clr_exp; exp_busy = 1; exp_cctrans = 1; exp_ccwrite = dirty; chk_idx = 1; exp_idx = ix;
            tick;
            if (dirty) begin
                for (int k = 0; k < 2; k++) begin
                    int   waits;
                    logic kb;
                    kb = k[0];
                    waits = rnd ? $urandom_range(0, 3) : 3;
                    for (int c = 0; c <= waits; c++) begin
                        dwait = (c < waits);
                        ccwait = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
                        ccinv = 1'($urandom);
                        clr_exp; exp_busy = 1; exp_dwen = 1; chk_idx = 1; exp_idx = ix;
                        exp_daddr = {a[31:3], kb, 2'b00};
                        exp_dstore = fdat[ix][w][k];
                        if (k == 1 && c == waits) begin
                            exp_upd_en = 1; exp_upd_way = w[0]; exp_upd_valid = 1;
                        end
                        tick;
                    end
                end
                fd[ix][w] = 0;
            end
        end

        for (int c = 0; c < hold; c++) begin
            ccwait = 1; ccinv = 1'($urandom); dwait = 1'($urandom); ccsnoopaddr = $urandom;
            clr_exp; exp_busy = 1;
            tick;
        end
        ccwait = 0; ccinv = 1'($urandom);
        clr_exp;
        tick;
        ccsnoopaddr = $urandom;
        clr_exp; chk_idx = 1; exp_idx = ccsnoopaddr[5:3];
        tick;
    endtask

    task automatic clear_frames();
        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 2; w++) begin
                fv[s][w] = 0; fd[s][w] = 0; ft[s][w] = 0;
                fdat[s][w][0] = 0; fdat[s][w][1] = 0;
            end
    endtask

    task automatic random_frames();
        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 2; w++) begin
                fv[s][w] = 1'($urandom); fd[s][w] = 1'($urandom);
                ft[s][w] = 26'($urandom_range(0, 3));
                fdat[s][w][0] = $urandom; fdat[s][w][1] = $urandom;
            end
    endtask

    int t0, u0, d0;

    initial begin
        clear_frames();
        nRST = 0; ccwait = 0; ccinv = 0; dwait = 0; ccsnoopaddr = 0;
        clr_exp; chk_idx = 1; exp_idx = 0;
        tick; chk_on = 1;
        tick; tick;
        nRST = 1;
        clr_exp; chk_idx = 1; exp_idx = 0;
        tick;

        // Miss
        t0 = mon_trans; u0 = mon_upd;
        snoop(32'h0000_1040, 0, 2, 0);
        chk("miss_trans_count", mon_trans - t0, 1);
        chk("miss_ccwrite", last_ccwrite, 0);
        chk("miss_no_upd", mon_upd - u0, 0);

        // Clean hit in way1
        fv[1][1] = 1; fd[1][1] = 0; ft[1][1] = 26'h81;
        t0 = mon_trans; d0 = mon_dwen; u0 = mon_upd;
        snoop(32'h0000_2048, 0, 1, 0);
        chk("shit_trans_count", mon_trans - t0, 1);
        chk("shit_ccwrite", last_ccwrite, 0);
        chk("shit_no_dwen", mon_dwen - d0, 0);
        chk("shit_no_upd", mon_upd - u0, 0);

        // Modified hit in way0, write-back
        fv[1][0] = 1; fd[1][0] = 1; ft[1][0] = 26'h40;
        fdat[1][0][0] = 32'hDEAD_BEEF; fdat[1][0][1] = 32'h1234_5678;
        wbq.delete();
        snoop(32'h0000_1008, 0, 1, 0);
        chk("mhit_ccwrite", last_ccwrite, 1);
        chk("mhit_wb_count", wbq.size(), 2);
        if (wbq.size() == 2) begin
            chk("mhit_wb0", wbq[0], {32'h0000_1008, 32'hDEAD_BEEF});
            chk("mhit_wb1", wbq[1], {32'h0000_100C, 32'h1234_5678});
        end
        chk("mhit_upd", {last_upd_way, last_upd_valid, last_upd_dirty}, 3'b010);

        // Invalidate way1
        t0 = mon_trans; u0 = mon_upd;
        snoop(32'h0000_2048, 1, 3, 0);
        chk("inv_upd_count", mon_upd - u0, 1);
        chk("inv_upd", {last_upd_way, last_upd_valid, last_upd_dirty}, 3'b100);
        chk("inv_no_trans", mon_trans - t0, 0);

        // Hold-off: long ccwait after a clean snoop
        t0 = mon_trans;
        snoop(32'h0000_1008, 0, 10, 0);
        chk("holdoff_trans_count", mon_trans - t0, 1);

        // Reset in the middle of a write-back
        fv[2][0] = 1; fd[2][0] = 1; ft[2][0] = 26'd5; fdat[2][0][0] = 32'hCAFE_0001;
        ccwait = 1; ccinv = 0; ccsnoopaddr = 32'h0000_0150; dwait = 1;
        clr_exp; exp_busy = 1; chk_idx = 1; exp_idx = 3'd2;
        tick;
        clr_exp; exp_busy = 1; exp_cctrans = 1; exp_ccwrite = 1; chk_idx = 1; exp_idx = 3'd2;
        tick;
        clr_exp; exp_busy = 1; exp_dwen = 1; exp_daddr = 32'h0000_0150;
        exp_dstore = 32'hCAFE_0001; chk_idx = 1; exp_idx = 3'd2;
        tick;
        nRST = 0;
        clr_exp; chk_idx = 1; exp_idx = 0;
        tick; tick;
        nRST = 1; ccwait = 0;
        clr_exp; chk_idx = 1; exp_idx = 3'd2;
        tick;
        snoop(32'h0000_0150, 0, 0, 1);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            if (n % 10 == 0) random_frames();
            snoop({26'($urandom_range(0, 3)), 6'($urandom)}, ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 4), 1);
        end

        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
